fifo64x32_rd_streamer: RTL

//  Read-side engine for the 64x32 standard-mode FIFO. It drains exactly burst_len words per start

---
 rtl/fifo64x32_rd_streamer_if.sv | 24 ++
 rtl/fifo64x32_rd_streamer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fifo64x32_rd_streamer_if.sv
// Valid/ready stream carrying words drained from the FIFO to downstream logic.
// The master drives data/valid/last; the slave drives ready.
interface fifo64x32_rd_streamer_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/fifo64x32_rd_streamer.sv
// Read-side burst engine for the 64x32 FIFO: drains burst_len words per start command into a
// valid/ready stream, with a 2-entry skid buffer covering the FIFO's 1-cycle read latency.
module fifo64x32_rd_streamer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      burst_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_W-1:0]     fifo_dout_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  fifo64x32_rd_streamer_if.master m_if
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  sent_q, sent_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic [1:0]        cnt_q, cnt_d;
  logic              inflight_q;

  logic [1:0]        occ;
  logic [LEN_W-1:0]  last_idx;
  logic              rd_en;
  logic              tvalid;
  logic              hs;

  assign occ      = cnt_q + {1'b0, inflight_q};
  assign last_idx = len_q - {{(LEN_W-1){1'b0}}, 1'b1};
  assign rd_en    = (state_q == StRun) & ~fifo_empty_i & (issued_q < len_q) & (occ < 2'd2);

  // The word arriving from the FIFO is presented directly when the buffer is empty, which
  // keeps rd_en-to-valid at one cycle and sustains one beat per clock within 2 entries.
  assign tvalid = (cnt_q != 2'd0) | inflight_q;
  assign hs     = tvalid & m_if.m_tready;

  always_comb begin
    m_if.m_tvalid = tvalid;
    m_if.m_tlast  = tvalid & (sent_q == last_idx);
    if (cnt_q != 2'd0) begin
      m_if.m_tdata = buf_q[0];
    end else if (inflight_q) begin
      m_if.m_tdata = fifo_dout_i;
    end else begin
      m_if.m_tdata = '0;
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign busy_o       = (state_q == StRun);
  assign done_o       = (state_q == StFin);

  // Pop the head first, then append the arriving word unless it was consumed via the bypass.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (hs && (cnt_q != 2'd0)) begin
      buf_d[0] = buf_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (inflight_q && !(hs && (cnt_q == 2'd0))) begin
      buf_d[cnt_d[0]] = fifo_dout_i;
      cnt_d           = cnt_d + 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    if (rd_en) begin
      issued_d = issued_q + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    if (hs) begin
      sent_d = sent_q + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d    = burst_len_i;
          issued_d = '0;
          sent_d   = '0;
          state_d  = (burst_len_i == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        if (hs && (sent_q == last_idx)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      buf_q      <= '{default: '0};
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      inflight_q <= rd_en;
    end
  end

endmodule
